// File: rtl/threshold_monitor.sv
// Debounced hysteresis alarm on a sample stream, with the high threshold held locally for bank readback.
// Optional alarm-entry counter enabled by defining ALARM_COUNT_EN.
module threshold_monitor #(
  parameter int unsigned HOLD_CNT = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] thr_i,
  input  logic        thr_wr_i,
  output logic [31:0] thr_rb_o,
  input  logic [15:0] sample_i,
  input  logic        sample_valid_i,
  output logic        alarm_o,
  output logic        alarm_rise_o,
  output logic        alarm_fall_o,
  output logic [1:0]  state_o,
  input  logic        alarm_cnt_clr_i,
  output logic [15:0] alarm_cnt_o
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] HOLD_W = CW'(HOLD_CNT);
  localparam logic          HOLD_ONE = (HOLD_CNT == 1);

  typedef enum logic [1:0] {
    NORMAL    = 2'd0,
    ARMING    = 2'd1,
    ALARM     = 2'd2,
    RELEASING = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   high_thr_q, high_thr_d;
  logic          alarm_q, alarm_d;
  logic          rise_q, fall_q;

  logic hi_hit, lo_hit, last_hit;

  assign hi_hit   = sample_i > high_thr_q;
  assign lo_hit   = sample_i < thr_i[15:0];
  assign last_hit = (cnt_q + CW'(1)) == HOLD_W;

  // Next-state: debounce counter restarts whenever a sample fails to qualify.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_thr_d = thr_wr_i ? thr_i[31:16] : high_thr_q;
    if (sample_valid_i) begin
      case (state_q)
        NORMAL: begin
          if (hi_hit) begin
            if (HOLD_ONE) begin
              state_d = ALARM;
              cnt_d   = '0;
            end else begin
              state_d = ARMING;
              cnt_d   = CW'(1);
            end
          end
        end
        ARMING: begin
          if (!hi_hit) begin
            state_d = NORMAL;
            cnt_d   = '0;
          end else if (last_hit) begin
            state_d = ALARM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ALARM: begin
          if (lo_hit) begin
            if (HOLD_ONE) begin
              state_d = NORMAL;
              cnt_d   = '0;
            end else begin
              state_d = RELEASING;
              cnt_d   = CW'(1);
            end
          end
        end
        RELEASING: begin
          if (!lo_hit) begin
            state_d = ALARM;
            cnt_d   = '0;
          end else if (last_hit) begin
            state_d = NORMAL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = NORMAL;
          cnt_d   = '0;
        end
      endcase
    end
    alarm_d = (state_d == ALARM) || (state_d == RELEASING);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= NORMAL;
      cnt_q      <= '0;
      high_thr_q <= 16'hFFFF;
      alarm_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_thr_q <= high_thr_d;
      alarm_q    <= alarm_d;
      rise_q     <= alarm_d & ~alarm_q;
      fall_q     <= ~alarm_d & alarm_q;
    end
  end

  assign thr_rb_o     = {high_thr_q, 16'h0000};
  assign alarm_o      = alarm_q;
  assign alarm_rise_o = rise_q;
  assign alarm_fall_o = fall_q;
  assign state_o      = state_q;

`ifdef ALARM_COUNT_EN
  logic [15:0] acnt_q;

  // Saturating entry counter; clear has priority over a coincident rise.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acnt_q <= '0;
    end else if (alarm_cnt_clr_i) begin
      acnt_q <= '0;
    end else if (rise_q && (acnt_q != 16'hFFFF)) begin
      acnt_q <= acnt_q + 16'd1;
    end
  end

  assign alarm_cnt_o = acnt_q;
`else
  logic unused_clr;
  assign unused_clr  = alarm_cnt_clr_i;
  assign alarm_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_threshold_monitor.sv
// Self-checking bench for threshold_monitor: directed scenarios plus random traffic vs. a run-length model.
module tb_threshold_monitor;

  localparam int unsigned HOLD = 4;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [31:0] thr_i = 32'h0;
  logic        thr_wr_i = 1'b0;
  logic [31:0] thr_rb_o;
  logic [15:0] sample_i = 16'h0;
  logic        sample_valid_i = 1'b0;
  logic        alarm_o, alarm_rise_o, alarm_fall_o;
  logic [1:0]  state_o;
  logic        alarm_cnt_clr_i = 1'b0;
  logic [15:0] alarm_cnt_o;

  threshold_monitor #(.HOLD_CNT(HOLD)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .thr_i(thr_i), .thr_wr_i(thr_wr_i),
    .thr_rb_o(thr_rb_o), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
    .alarm_o(alarm_o), .alarm_rise_o(alarm_rise_o), .alarm_fall_o(alarm_fall_o),
    .state_o(state_o), .alarm_cnt_clr_i(alarm_cnt_clr_i), .alarm_cnt_o(alarm_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Reference model: alarm flag plus length of the current qualifying run.
  logic [15:0] m_high;
  bit          m_alarm, m_rise, m_fall;
  int          m_run;
  int          m_acnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_high = 16'hFFFF; m_alarm = 0; m_rise = 0; m_fall = 0; m_run = 0; m_acnt = 0;
  endtask

  task automatic model_step();
    bit hi, lo, was;
    hi  = sample_i > m_high;
    lo  = sample_i < thr_i[15:0];
    was = m_alarm;
`ifdef ALARM_COUNT_EN
    if (alarm_cnt_clr_i) m_acnt = 0;
    else if (m_rise && m_acnt != 65535) m_acnt++;
`endif
    if (sample_valid_i) begin
      if ((!m_alarm && hi) || (m_alarm && lo)) begin
        m_run++;
        if (m_run == HOLD) begin
          m_alarm = !m_alarm;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    m_rise = m_alarm && !was;
    m_fall = !m_alarm && was;
    if (thr_wr_i) m_high = thr_i[31:16];
  endtask

  task automatic check_all();
    int exp_state;
    exp_state = m_alarm ? (m_run > 0 ? 3 : 2) : (m_run > 0 ? 1 : 0);
    chk("state", 32'(state_o), 32'(exp_state));
    chk("alarm", 32'(alarm_o), 32'(m_alarm));
    chk("rise", 32'(alarm_rise_o), 32'(m_rise));
    chk("fall", 32'(alarm_fall_o), 32'(m_fall));
    chk("thr_rb", thr_rb_o, {m_high, 16'h0000});
    chk("alarm_cnt", 32'(alarm_cnt_o), 32'(m_acnt));
  endtask

  task automatic cyc(input logic v, input logic [15:0] s, input logic wr,
                     input logic [31:0] thr, input logic clr);
    sample_valid_i = v; sample_i = s; thr_wr_i = wr; thr_i = thr; alarm_cnt_clr_i = clr;
    @(posedge clk_i);
    model_step();
    #1;
    check_all();
  endtask

  task automatic samp(input logic [15:0] s, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, s, 1'b0, 32'h0800_0100, 1'b0);
  endtask

  initial begin
    logic [31:0] cur_thr;
    model_reset();
    #23;
    chk("reset_rb", thr_rb_o, 32'hFFFF_0000);
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_alarm", 32'(alarm_o), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    check_all();

    // Threshold write and readback
    cyc(1'b0, 16'h0, 1'b1, 32'h0800_0100, 1'b0);
    chk("rb_after_wr", thr_rb_o, 32'h0800_0000);

    // Entry and exit
    samp(16'h0900, 3);
    chk("no_alarm_3", 32'(alarm_o), 32'd0);
    samp(16'h0900, 1);
    chk("entry_alarm", 32'(alarm_o), 32'd1);
    chk("entry_rise", 32'(alarm_rise_o), 32'd1);
    samp(16'h0900, 1);
    chk("rise_one_cycle", 32'(alarm_rise_o), 32'd0);
    samp(16'h0050, 4);
    chk("exit_alarm", 32'(alarm_o), 32'd0);
    chk("exit_fall", 32'(alarm_fall_o), 32'd1);

    // Debounce restart and valid gaps
    samp(16'h0900, 3);
    samp(16'h0800, 1);
    chk("restart_state", 32'(state_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 16'h0900, 1'b0, 32'h0800_0100, 1'b0);
      cyc(1'b0, 16'h0000, 1'b0, 32'h0800_0100, 1'b0);
    end
    chk("gap_alarm", 32'(alarm_o), 32'd1);

    // Midband and equality with low while alarmed
    samp(16'h0100, 3);
    chk("eq_low_stays", 32'(state_o), 32'd2);
    samp(16'h0050, 2);
    samp(16'h0400, 1);
    chk("mid_back_alarm", 32'(state_o), 32'd2);
    samp(16'h0050, 4);
    samp(16'h0800, 10);
    chk("eq_high_noalarm", 32'(alarm_o), 32'd0);

    // Asynchronous reset mid-arming
    samp(16'h0900, 2);
    chk("arming2", 32'(state_o), 32'd1);
    #2 rst_n_i = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_state", 32'(state_o), 32'd0);
    chk("mid_rst_rb", thr_rb_o, 32'hFFFF_0000);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    cyc(1'b0, 16'h0, 1'b1, 32'h0800_0100, 1'b0);
    samp(16'h0900, 3);
    chk("post_rst_cnt0", 32'(alarm_o), 32'd0);
    samp(16'h0900, 1);
    samp(16'h0050, 4);

`ifdef ALARM_COUNT_EN
    cyc(1'b0, 16'h0, 1'b0, 32'h0800_0100, 1'b1);
    for (int k = 0; k < 3; k++) begin
      samp(16'h0900, 4);
      samp(16'h0050, 4);
    end
    chk("cnt_three", 32'(alarm_cnt_o), 32'd3);
    samp(16'h0900, 4);
    cyc(1'b1, 16'h0900, 1'b0, 32'h0800_0100, 1'b1);
    chk("cnt_clr_wins", 32'(alarm_cnt_o), 32'd0);
`else
    cyc(1'b0, 16'h0, 1'b0, 32'h0800_0100, 1'b1);
    chk("cnt_disabled", 32'(alarm_cnt_o), 32'd0);
`endif

    // Random traffic, including low>high and write coincident with samples
    cur_thr = 32'h0800_0100;
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] s;
      logic wr;
      wr = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        cur_thr = {16'($urandom_range(32'h200, 32'hA00)), 16'($urandom_range(32'h100, 32'h900))};
        wr = 1'($urandom_range(0, 1));
      end
      case ($urandom_range(0, 5))
        0:       s = m_high;
        1:       s = cur_thr[15:0];
        default: s = 16'($urandom_range(0, 32'hC00));
      endcase
      cyc(1'($urandom_range(0, 3) != 0), s, wr, cur_thr, 1'($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
